// File: rtl/dmux8way16_buf.sv
// Buffered 16-bit 1-to-8 demultiplexer: one producer word is steered into one of eight
// single-entry output registers, each with an independent valid/ready handshake.
module dmux8way16_buf (
  input  logic         clock,
  input  logic         rst_n,
  input  logic [15:0]  in,
  input  logic [2:0]   sel,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] out,
  output logic [7:0]   out_valid,
  input  logic [7:0]   out_ready,
  output logic [15:0]  count
);

  logic [15:0] r_buf [8];
  logic [7:0]  r_full;
  logic [15:0] r_count;
  logic        w_accept;
  logic [7:0]  w_wr_sel;

  // A full channel can still take a word in the cycle its consumer drains it.
  always_comb begin
    in_ready      = rst_n & (~r_full[sel] | out_ready[sel]);
    w_accept      = in_valid & in_ready;
    w_wr_sel      = 8'h00;
    w_wr_sel[sel] = w_accept;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) begin
        r_buf[k] <= 16'h0000;
      end
      r_full  <= 8'h00;
      r_count <= 16'h0000;
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (w_wr_sel[k]) begin
          r_buf[k]  <= in;
          r_full[k] <= 1'b1;
        end else if (out_ready[k]) begin
          r_full[k] <= 1'b0;
        end
      end
      if (w_accept) begin
        r_count <= r_count + 16'd1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      out[16*k +: 16] = r_buf[k];
    end
    out_valid = r_full;
    count     = r_count;
  end

endmodule

// File: tb/tb_dmux8way16_buf.sv
// Self-checking bench for dmux8way16_buf: table-driven vectors, a per-channel scoreboard of
// words in flight, and hand-written stall, async-reset and count-wrap sequences.
module tb_dmux8way16_buf;

  logic         clock = 1'b0;
  logic         rst_n;
  logic [15:0]  in;
  logic [2:0]   sel;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] out;
  logic [7:0]   out_valid;
  logic [7:0]   out_ready;
  logic [15:0]  count;

  dmux8way16_buf dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .in        (in),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clock = ~clock;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model and scoreboard of words awaiting delivery per channel.
  logic [7:0]   m_full;
  logic [127:0] m_out;
  logic [15:0]  m_count;
  logic [15:0]  sb_q [8][$];

  typedef struct {
    logic        v;
    logic [2:0]  s;
    logic [15:0] d;
    logic [7:0]  r;
    logic        e_rdy;
    logic [7:0]  e_val;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_full  = 8'h00;
    m_out   = '0;
    m_count = 16'h0000;
    for (int k = 0; k < 8; k++) sb_q[k].delete();
  endtask

  // Called one time unit after a rising edge; returns the in_ready seen before the next edge.
  task automatic step(input logic v, input logic [2:0] s, input logic [15:0] d,
                      input logic [7:0] r, output logic rdy);
    logic        exp_rdy;
    logic [15:0] w;
    in_valid  = v;
    sel       = s;
    in        = d;
    out_ready = r;
    #1;
    rdy     = in_ready;
    exp_rdy = ~m_full[s] | r[s];
    check("in_ready", {127'b0, in_ready}, {127'b0, exp_rdy});
    for (int k = 0; k < 8; k++) begin
      if (m_full[k] && r[k]) begin
        if (sb_q[k].size() == 0) begin
          check("sb_nonempty", 128'd0, 128'd1);
        end else begin
          w = sb_q[k].pop_front();
          check("drain_data", {112'b0, out[16*k +: 16]}, {112'b0, w});
        end
        m_full[k] = 1'b0;
      end
    end
    if (v && exp_rdy) begin
      sb_q[s].push_back(d);
      m_full[s]           = 1'b1;
      m_out[16*s +: 16]   = d;
      m_count             = m_count + 16'd1;
    end
    @(posedge clock);
    #1;
    check("out_valid", {120'b0, out_valid}, {120'b0, m_full});
    check("count", {112'b0, count}, {112'b0, m_count});
    check("out", out, m_out);
  endtask

  // Asynchronous reset pulse taken mid-cycle; checks the cleared state before any edge.
  task automatic do_reset();
    in_valid = 1'b1;
    rst_n    = 1'b0;
    #2;
    check("rst_out_valid", {120'b0, out_valid}, 128'd0);
    check("rst_out", out, 128'd0);
    check("rst_count", {112'b0, count}, 128'd0);
    check("rst_in_ready", {127'b0, in_ready}, 128'd0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    model_clear();
    @(posedge clock);
    #1;
  endtask

  logic rdy;

  initial begin
    tbl[0]  = '{1'b1, 3'd5, 16'h1234, 8'h00, 1'b1, 8'h20, 16'd1};
    tbl[1]  = '{1'b1, 3'd5, 16'hBEEF, 8'h00, 1'b0, 8'h20, 16'd1};
    tbl[2]  = '{1'b1, 3'd5, 16'hBEEF, 8'h20, 1'b1, 8'h20, 16'd2};
    tbl[3]  = '{1'b0, 3'd0, 16'h0000, 8'h20, 1'b1, 8'h00, 16'd2};
    for (int k = 0; k < 8; k++) begin
      tbl[4+k] = '{1'b1, 3'(k), 16'hA000 + 16'(k), 8'h00, 1'b1, 8'(9'h1FF >> (8 - k)) | 8'(1 << k),
                   16'(3 + k)};
    end
    tbl[12] = '{1'b0, 3'd0, 16'h0000, 8'hFF, 1'b1, 8'h00, 16'd10};

    rst_n     = 1'b0;
    in        = 16'h0000;
    sel       = 3'd0;
    in_valid  = 1'b1;
    out_ready = 8'h00;
    model_clear();
    #3;
    check("init_out_valid", {120'b0, out_valid}, 128'd0);
    check("init_count", {112'b0, count}, 128'd0);
    check("init_out", out, 128'd0);
    check("init_in_ready", {127'b0, in_ready}, 128'd0);
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].r, rdy);
      check($sformatf("tbl%0d_rdy", i), {127'b0, rdy}, {127'b0, tbl[i].e_rdy});
      check($sformatf("tbl%0d_valid", i), {120'b0, out_valid}, {120'b0, tbl[i].e_val});
      check($sformatf("tbl%0d_count", i), {112'b0, count}, {112'b0, tbl[i].e_cnt});
    end

    // Stalled channel 2 blocks its producer; a later offer to channel 6 leaves it untouched.
    step(1'b1, 3'd2, 16'h2222, 8'h00, rdy);
    step(1'b1, 3'd2, 16'h3333, 8'h00, rdy);
    check("stall_rdy", {127'b0, rdy}, 128'd0);
    check("stall_ch2", {112'b0, out[47:32]}, {112'b0, 16'h2222});
    step(1'b0, 3'd2, 16'h3333, 8'h00, rdy);
    step(1'b1, 3'd6, 16'h6666, 8'h00, rdy);
    check("ch6_rdy", {127'b0, rdy}, 128'd1);
    check("ch6_valid", {120'b0, out_valid}, {120'b0, 8'h44});
    check("ch6_ch2", {112'b0, out[47:32]}, {112'b0, 16'h2222});
    check("ch6_data", {112'b0, out[111:96]}, {112'b0, 16'h6666});

    do_reset();
    for (int i = 0; i < 35; i++) step(1'b1, 3'd1, 16'(i), 8'h02, rdy);
    step(1'b1, 3'd0, 16'hC0C0, 8'h02, rdy);
    step(1'b1, 3'd7, 16'hD7D7, 8'h00, rdy);
    check("pre_rst_valid", {120'b0, out_valid}, {120'b0, 8'h81});
    check("pre_rst_count", {112'b0, count}, 128'd37);
    do_reset();

    for (int i = 0; i < 65534; i++) step(1'b1, 3'(i), 16'(i), 8'hFF, rdy);
    check("wrap_fffe", {112'b0, count}, {112'b0, 16'hFFFE});
    step(1'b1, 3'd3, 16'h5A5A, 8'hFF, rdy);
    check("wrap_ffff", {112'b0, count}, {112'b0, 16'hFFFF});
    step(1'b1, 3'd4, 16'hA5A5, 8'hFF, rdy);
    check("wrap_0000", {112'b0, count}, 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
